// File: rtl/kt_cmd_pkg.sv
// Shared Knight command constants, response bytes, error codes and sequencer states.
// Pure declarations: no latency, no flow control.
package kt_cmd_pkg;

  localparam logic [3:0] OP_CAL     = 4'h2;
  localparam logic [3:0] OP_MOVE    = 4'h4;
  localparam logic [3:0] OP_FANFARE = 4'h5;
  localparam logic [3:0] OP_TOUR    = 4'h6;

  localparam logic [7:0] ACK_FINAL_DEF = 8'hA5;
  localparam logic [7:0] ACK_STEP_DEF  = 8'h5A;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_RESP    = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_OVF     = 2'b11
  } err_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_SENT,
    ST_WAIT_RESP,
    ST_DONE,
    ST_ERR
  } seq_state_t;

endpackage

// File: rtl/seq_cmd_mem.sv
// DEPTH x 16 command list: one write per cycle, combinational read; 0-cycle read latency.
// A write while full is dropped and flagged on ovf in the same cycle; clr wins over a write.
module seq_cmd_mem #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [15:0]              wr_data,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [15:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0] mem [DEPTH];
  logic        wr_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign wr_ok = wr_en && !clr && !full;
  assign ovf   = wr_en && !clr && full;

  // The low bits of count double as the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (wr_ok) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[count[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/rmt_cmd_sequencer.sv
// Issues a stored Knight command list to RemoteComm, 2 clocks from ACK_FINAL to next send_cmd;
// waits on cmd_sent/resp_rdy indefinitely unless SEQ_TIMEOUT_EN adds a per-command watchdog.
module rmt_cmd_sequencer
  import kt_cmd_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [7:0]  ACK_FINAL   = ACK_FINAL_DEF,
  parameter logic [7:0]  ACK_STEP    = ACK_STEP_DEF,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [15:0]              wr_data,
  input  logic                     clr,
  input  logic                     start,
  output logic [15:0]              cmd,
  output logic                     send_cmd,
  input  logic                     cmd_sent,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH)-1:0] cmd_idx,
  output logic [5:0]               step_cnt
);

  localparam int AW = $clog2(DEPTH);

  seq_state_t  state;
  logic [15:0] rd_data;
  logic [AW:0] count;
  logic        full;
  logic        ovf;
  logic        wr_ok;
  logic        clr_ok;
  logic        waiting;
  logic        resp_hit;
  logic        is_last;
  logic        wdog_hit;

  assign wr_ok   = wr_en && !busy;
  assign clr_ok  = clr && !busy;
  assign waiting = (state == ST_WAIT_SENT) || (state == ST_WAIT_RESP);
  // A response coinciding with cmd_sent is handled as if already in WAIT_RESP.
  assign resp_hit = resp_rdy && ((state == ST_WAIT_RESP) || (state == ST_WAIT_SENT && cmd_sent));
  assign is_last  = ({1'b0, cmd_idx} == count - 1'b1);

  seq_cmd_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_data (wr_data),
    .clr     (clr_ok),
    .rd_idx  (cmd_idx),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .ovf     (ovf)
  );

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] wdog;

  assign wdog_hit = waiting && (wdog + 32'd1 >= TIMEOUT_CYC);

  // Restarted per command and per response, so a long tour only needs steady progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (state == ST_LOAD || resp_rdy) begin
      wdog <= '0;
    end else if (waiting) begin
      wdog <= wdog + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
  assign wdog_hit       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cmd      <= 16'h0000;
      send_cmd <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      cmd_idx  <= '0;
      step_cnt <= '0;
    end else begin
      send_cmd <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (clr_ok) begin
            state    <= ST_IDLE;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            cmd_idx  <= '0;
            step_cnt <= '0;
          end else if (start) begin
            if (count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_LOAD;
              busy     <= 1'b1;
              cmd_idx  <= '0;
              done     <= 1'b0;
              err      <= 1'b0;
              err_code <= ERR_NONE;
            end
          end else if (ovf) begin
            err      <= 1'b1;
            err_code <= ERR_OVF;
          end
        end
        ST_LOAD: begin
          cmd      <= rd_data;
          step_cnt <= '0;
          send_cmd <= 1'b1;
          state    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          state <= ST_WAIT_SENT;
        end
        ST_WAIT_SENT, ST_WAIT_RESP: begin
          if (resp_hit) begin
            if (resp == ACK_STEP) begin
              state <= ST_WAIT_RESP;
              if (step_cnt != 6'd63) begin
                step_cnt <= step_cnt + 6'd1;
              end
            end else if (resp == ACK_FINAL) begin
              if (is_last) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                cmd_idx <= cmd_idx + 1'b1;
                state   <= ST_LOAD;
              end
            end else begin
              state    <= ST_ERR;
              err      <= 1'b1;
              err_code <= ERR_RESP;
              busy     <= 1'b0;
            end
          end else if (wdog_hit) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            busy     <= 1'b0;
          end else if (state == ST_WAIT_SENT && cmd_sent) begin
            state <= ST_WAIT_RESP;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmt_cmd_sequencer.sv
// Randomized bench: a scripted Knight drives the sequencer, outcomes are predicted from the list and reply plan.
module tb_rmt_cmd_sequencer;

  localparam int DEPTH = 16;
  localparam int TO    = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        cmd_sent = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [3:0]  cmd_idx;
  logic [5:0]  step_cnt;

  int checks = 0;
  int failures = 0;

  logic [15:0] wq[$];
  int          sq[$];
  logic [15:0] sent_q[$];

  rmt_cmd_sequencer #(
    .DEPTH(DEPTH), .ACK_FINAL(8'hA5), .ACK_STEP(8'h5A), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr), .start(start),
    .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .cmd_idx(cmd_idx), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // Every cycle send_cmd is high is logged, so a stretched or spurious pulse shows up as an extra entry.
  always @(negedge clk) if (send_cmd === 1'b1) sent_q.push_back(cmd);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd"}, cmd, 16'h0000);
    chk({tag, "_send"}, send_cmd, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_code"}, err_code, 0);
    chk({tag, "_idx"}, cmd_idx, 0);
    chk({tag, "_step"}, step_cnt, 0);
  endtask

  // Plays the list in wq with sq[i] step bytes per command; bad_at (or -1) gets a non-ACK byte.
  task automatic run_seq(input int bad_at, input logic [7:0] bad_byte, input int sent_delay);
    int n, nexp, gap, first, stp;
    logic [7:0] bytes[$];
    logic [7:0] b;
    n = (wq.size() > DEPTH) ? DEPTH : wq.size();
    clr = 1'b1; tick(); clr = 1'b0;
    foreach (wq[i]) begin
      wr_en = 1'b1; wr_data = wq[i]; tick();
    end
    wr_en = 1'b0;
    chk("wr_err", err, wq.size() > DEPTH);
    if (wq.size() > DEPTH) chk("ovf_code", err_code, 2'b11);
    sent_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    if (n == 0) begin
      chk("empty_done", done, 1);
      chk("empty_busy", busy, 0);
      repeat (3) tick();
      chk("empty_pulses", sent_q.size(), 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      gap = 1;
      while (send_cmd !== 1'b1 && gap < 50) begin tick(); gap++; end
      if (send_cmd !== 1'b1) begin chk("send_wait", 0, 1); break; end
      chk("ack_to_send", gap, 2);
      chk("issue_cmd", cmd, wq[i]);
      chk("issue_busy", busy, 1);
      tick();
      chk("pulse_len", send_cmd, 0);
      bytes.delete();
      for (int k = 0; k < sq[i]; k++) bytes.push_back(8'h5A);
      if (i == bad_at) begin
        b = bad_byte;
        while (b == 8'hA5 || b == 8'h5A) b = 8'($urandom);
        bytes.push_back(b);
      end else begin
        bytes.push_back(8'hA5);
      end
      repeat ((sent_delay < 0) ? $urandom_range(0, 6) : sent_delay) tick();
      cmd_sent = 1'b1; first = 0;
      if ($urandom_range(0, 1) == 1) begin resp_rdy = 1'b1; resp = bytes[0]; first = 1; end
      tick();
      cmd_sent = 1'b0; resp_rdy = 1'b0;
      for (int k = first; k < bytes.size(); k++) begin
        repeat ($urandom_range(0, 2)) tick();
        resp_rdy = 1'b1; resp = bytes[k]; tick(); resp_rdy = 1'b0;
      end
      if (i == bad_at) break;
    end
    repeat (3) tick();
    nexp = (bad_at >= 0 && bad_at < n) ? bad_at + 1 : n;
    stp  = (sq[nexp-1] > 63) ? 63 : sq[nexp-1];
    chk("pulses", sent_q.size(), nexp);
    for (int i = 0; i < sent_q.size() && i < nexp; i++) chk("sent_order", sent_q[i], wq[i]);
    chk("end_done", done, nexp == n && bad_at < 0);
    chk("end_err", err, bad_at >= 0);
    chk("end_code", err_code, (bad_at >= 0) ? 1 : 0);
    chk("end_busy", busy, 0);
    chk("end_idx", cmd_idx, nexp - 1);
    chk("end_step", step_cnt, stp);
  endtask

  initial begin
    int n, t;
    rst = 1'b0;
    #1 rst = 1'b1;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    wq = '{16'h2000}; sq = '{0};
    run_seq(-1, 8'h00, 20);

    wq = '{16'h4001, 16'h4402, 16'h43F2}; sq = '{0, 0, 0};
    run_seq(-1, 8'h00, -1);

    wq = '{16'h6022}; sq = '{3};
    run_seq(-1, 8'h00, -1);

    // A stray byte outside a sequence must not disturb the status.
    resp_rdy = 1'b1; resp = 8'h3C; tick(); resp_rdy = 1'b0; tick();
    chk("idle_resp_done", done, 1);
    chk("idle_resp_err", err, 0);

    wq = '{16'h4001, 16'h4002}; sq = '{0, 0};
    run_seq(0, 8'h3C, -1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_done", done, 0);
    chk("clr_err", err, 0);
    chk("clr_code", err_code, 0);
    chk("clr_idx", cmd_idx, 0);
    run_seq(-1, 8'h00, -1);

    wq.delete(); sq.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin wq.push_back(16'($urandom)); sq.push_back(0); end
    run_seq(-1, 8'h00, -1);

    wq = '{16'h6123, 16'h2000}; sq = '{70, 1};
    run_seq(-1, 8'h00, -1);
    wq = '{16'h6123, 16'h4555}; sq = '{70, 2};
    run_seq(0, 8'h00, -1);

    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, DEPTH);
      wq.delete(); sq.delete();
      for (int i = 0; i < n; i++) begin
        wq.push_back(16'($urandom));
        sq.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
      end
      run_seq((n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1, 8'h00, -1);
    end

    // Reset while waiting for a response; the list must be gone afterwards.
    clr = 1'b1; tick(); clr = 1'b0;
    wr_en = 1'b1; wr_data = 16'h4001; tick(); wr_data = 16'h4002; tick(); wr_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    t = 0;
    while (send_cmd !== 1'b1 && t < 50) begin tick(); t++; end
    chk("rst_seq_sent", send_cmd, 1);
    tick();
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0; tick();
    chk("rst_seq_busy", busy, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    tick(); rst = 1'b0; tick();
    sent_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    chk("midrst_empty_done", done, 1);
    chk("midrst_empty_busy", busy, 0);

    // Response silence after send_cmd.
    clr = 1'b1; tick(); clr = 1'b0;
    wr_en = 1'b1; wr_data = 16'h5321; tick(); wr_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    t = 0;
    while (send_cmd !== 1'b1 && t < 50) begin tick(); t++; end
    chk("to_sent", send_cmd, 1);
    t = 0;
    while (err !== 1'b1 && t < 5000) begin tick(); t++; end
`ifdef SEQ_TIMEOUT_EN
    chk("to_err", err, 1);
    chk("to_code", err_code, 2'b10);
    chk("to_busy", busy, 0);
    chk("to_cycles", (t >= TO - 1 && t <= TO + 1), 1);
`else
    chk("no_to_busy", busy, 1);
    chk("no_to_err", err, 0);
`endif
    rst = 1'b1; tick(); rst = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rmt_cmd_sequencer.md
Name: rmt_cmd_sequencer

Overview:
- Feeds RemoteComm from upstream. Holds a programmed list of 16-bit Knight commands (calibrate, move, move-with-fanfare, tour) and issues them one at a time.
- For each command it pulses send_cmd, waits for cmd_sent, then consumes resp_rdy/resp acknowledgements from the Knight before advancing.
- Used as the scripted host in system sims and as an FPGA-side autonomous tester.
- It is a queue plus a handshake FSM with response checking and a watchdog.

Parameters:
- DEPTH, 16, number of command slots (power of 2, minimum 2).
- ACK_FINAL, 8'hA5, response byte that completes a command.
- ACK_STEP, 8'h5A, intermediate response (one per tour move); the current command stays in progress.
- TIMEOUT_CYC, 32'd50_000_000, watchdog limit in clocks per command (used only with SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  push wr_data into the command list
- wr_data  in  16  command word (opcode[15:12], payload[11:0])
- clr  in  1  synchronous clear of the list and status; ignored while busy
- start  in  1  pulse; begins issuing from slot 0
- cmd  out  16  command to RemoteComm
- send_cmd  out  1  one-cycle pulse to RemoteComm
- cmd_sent  in  1  RemoteComm finished transmitting
- resp_rdy  in  1  response byte valid (one-cycle pulse)
- resp  in  8  response byte
- busy  out  1  sequence in progress
- done  out  1  sticky; all commands acknowledged
- err  out  1  sticky; sequence aborted
- err_code  out  2  00 none, 01 bad response, 10 timeout, 11 overflow on write
- cmd_idx  out  log2(DEPTH)  index of the current or last command
- step_cnt  out  6  ACK_STEP count for the current command (tour progress, maximum 63)

Behaviour:
- Reset (async, rst=1): state IDLE; wr_ptr=0, cmd_idx=0, step_cnt=0; cmd=16'h0000; send_cmd, busy, done, err=0; err_code=00.
- Writes are accepted in IDLE/DONE/ERR only. wr_en while busy is ignored.
- Writing when the list already holds DEPTH entries sets err=1 and err_code=11. The list is not modified.
- clr in a non-busy state sets wr_ptr=0 and clears done/err/err_code/step_cnt/cmd_idx.
- start with an empty list: done asserts the next cycle and busy stays 0. start while busy is ignored.
- FSM states: IDLE, LOAD, ISSUE, WAIT_SENT, WAIT_RESP, DONE, ERR.
- IDLE/DONE/ERR -> LOAD on start with count>0: cmd_idx=0; clears done, err and err_code.
- LOAD (1 cycle): cmd <= list[cmd_idx]; step_cnt <= 0; busy=1.
- ISSUE (1 cycle): send_cmd=1 for exactly this cycle.
- ISSUE -> WAIT_SENT.
- WAIT_SENT -> WAIT_RESP on cmd_sent.
- A resp_rdy arriving in the same cycle as cmd_sent is treated as received in WAIT_RESP.
- WAIT_RESP handling of resp_rdy:
  - resp==ACK_STEP: step_cnt increments, saturating at 63; state stays WAIT_RESP.
  - resp==ACK_FINAL: if cmd_idx==count-1 go to DONE (done=1, busy=0); otherwise cmd_idx++ and go to LOAD.
  - any other byte: go to ERR with err_code=01; busy=0; cmd_idx holds the failing slot.
- resp_rdy outside WAIT_RESP/WAIT_SENT is ignored.
- Latency: ACK_FINAL to the next send_cmd is exactly 2 clocks (LOAD, ISSUE).
- cmd holds its value stable from LOAD until the next LOAD. RemoteComm therefore sees a constant cmd across send_cmd.
- Mid-sequence reset returns everything to reset values. The stored list is lost because wr_ptr=0.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog clears on entry to ISSUE and on every resp_rdy.
  - It counts in WAIT_SENT and WAIT_RESP.
  - Reaching TIMEOUT_CYC goes to ERR with err_code=10.
  - A tour therefore only needs a response within TIMEOUT_CYC between moves.
- Undefined: no counter is synthesised, err_code=10 never occurs, and the sequencer waits indefinitely.

Decomposition:
- Shared package kt_cmd_pkg holds:
  - opcode constants: OP_CAL=4'h2, OP_MOVE=4'h4, OP_FANFARE=4'h5, OP_TOUR=4'h6;
  - the ACK_FINAL and ACK_STEP defaults;
  - the err_code enum;
  - the FSM state enum.
- One natural sub-module: seq_cmd_mem, a DEPTH x16 register file with write pointer, count and overflow flag. The FSM and watchdog stay in the top.

Test Plan:
- Load 16'h2000, start; cmd_sent after 20 clocks, resp 8'hA5 → exactly one send_cmd pulse with cmd=16'h2000; then done=1, busy=0, err_code=00.
- Load 16'h4001, 16'h4402, 16'h43F2; ack each with A5 → three send_cmd pulses in order; each pulse exactly 2 clocks after the previous A5; cmd_idx ends at 2; done=1.
- Load 16'h6022; send 5Ax3, then A5 → no new send_cmd after the 5A bytes; step_cnt=3; done=1 after A5.
- Load 16'h4001, 16'h4002; respond 8'h3C to the first → err=1, err_code=01, cmd_idx=0; the second command is never sent. Then clr and reload → status cleared.
- Write 17 words with DEPTH=16 → err_code=11 and count stays 16. Assert rst while in WAIT_RESP → all outputs return to reset values on the same edge.
- With SEQ_TIMEOUT_EN, TIMEOUT_CYC=1000: no cmd_sent after send_cmd → ERR with err_code=10 at 1000 clocks ±1. Without the macro → still busy at 5000 clocks.
